// File: rtl/ex_iter_if.sv
// Bundle of EX-stage instruction inputs, write-back outputs, ID forward, stall and HI/LO view.
// The slave modport is the EX stage; the master modport is whatever drives it.
interface ex_iter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              i_valid;
    logic [7:0]        i_aluop;
    logic [2:0]        i_alusel;
    logic [DATA_W-1:0] i_reg1;
    logic [DATA_W-1:0] i_reg2;
    logic [ADDR_W-1:0] i_waddr;
    logic              i_we;
    logic              i_flush;

    logic              o_valid;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [DATA_W-1:0] o_wdata;
    logic              o_we_id;
    logic [ADDR_W-1:0] o_waddr_id;
    logic [DATA_W-1:0] o_wdata_id;
    logic              o_stall;
    logic [DATA_W-1:0] o_hi;
    logic [DATA_W-1:0] o_lo;

    modport master (
        output i_valid, i_aluop, i_alusel, i_reg1, i_reg2, i_waddr, i_we, i_flush,
        input  o_valid, o_we, o_waddr, o_wdata, o_we_id, o_waddr_id, o_wdata_id,
        input  o_stall, o_hi, o_lo
    );

    modport slave (
        input  i_valid, i_aluop, i_alusel, i_reg1, i_reg2, i_waddr, i_we, i_flush,
        output o_valid, o_we, o_waddr, o_wdata, o_we_id, o_waddr_id, o_wdata_id,
        output o_stall, o_hi, o_lo
    );
endinterface

// File: rtl/ex_iter.sv
// Execute stage: single-cycle logic/shift/move ops plus an iterative restoring divider
// that owns the HI/LO registers and stalls upstream while it works.
module ex_iter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    ex_iter_if.slave bus
);

    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MFLO = 8'h12;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_divisor;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_valid;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_quot_nxt;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [DATA_W-1:0] w_divisor_nxt;
    logic              w_neg_q_nxt;
    logic              w_neg_r_nxt;
    logic [DATA_W-1:0] w_hi_nxt;
    logic [DATA_W-1:0] w_lo_nxt;
    logic              w_valid_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_waddr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_stall;

    logic [SH_W-1:0]   w_shamt;
    logic [DATA_W-1:0] w_logic_res;
    logic [DATA_W-1:0] w_shift_res;
    logic [DATA_W-1:0] w_move_res;
    logic [DATA_W-1:0] w_result;

    logic              w_is_div;
    logic              w_signed;
    logic              w_sign1;
    logic              w_sign2;
    logic [DATA_W-1:0] w_abs1;
    logic [DATA_W-1:0] w_abs2;
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_diff;
    logic              w_fits;
    logic [DATA_W-1:0] w_q_final;
    logic [DATA_W-1:0] w_r_final;

    // Single-cycle result path, also forwarded to ID
    assign w_shamt = bus.i_reg1[SH_W-1:0];

    always_comb begin
        w_logic_res = '0;
        w_shift_res = '0;
        w_move_res  = '0;
        case (bus.i_aluop)
            OP_AND:  w_logic_res = bus.i_reg1 & bus.i_reg2;
            OP_OR:   w_logic_res = bus.i_reg1 | bus.i_reg2;
            OP_XOR:  w_logic_res = bus.i_reg1 ^ bus.i_reg2;
            OP_NOR:  w_logic_res = ~(bus.i_reg1 | bus.i_reg2);
            default: w_logic_res = '0;
        endcase
        case (bus.i_aluop)
            OP_SLL:  w_shift_res = bus.i_reg2 << w_shamt;
            OP_SRL:  w_shift_res = bus.i_reg2 >> w_shamt;
            OP_SRA:  w_shift_res = $signed(bus.i_reg2) >>> w_shamt;
            default: w_shift_res = '0;
        endcase
        case (bus.i_aluop)
            OP_MFHI: w_move_res = r_hi;
            OP_MFLO: w_move_res = r_lo;
            default: w_move_res = '0;
        endcase
        case (bus.i_alusel)
            SEL_LOGIC: w_result = w_logic_res;
            SEL_SHIFT: w_result = w_shift_res;
            SEL_MOVE:  w_result = w_move_res;
            default:   w_result = '0;
        endcase
    end

    // Divider operand conditioning: magnitudes for DIV, raw for DIVU
    assign w_is_div = (bus.i_aluop == OP_DIV) || (bus.i_aluop == OP_DIVU);
    assign w_signed = (bus.i_aluop == OP_DIV);
    assign w_sign1  = w_signed & bus.i_reg1[DATA_W-1];
    assign w_sign2  = w_signed & bus.i_reg2[DATA_W-1];
    assign w_abs1   = w_sign1 ? -bus.i_reg1 : bus.i_reg1;
    assign w_abs2   = w_sign2 ? -bus.i_reg2 : bus.i_reg2;

    // Restoring step: dividend bits shift out of r_quot's MSB as quotient bits shift in
    assign w_rem_sh  = {r_rem, r_quot[DATA_W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_divisor};
    assign w_fits    = ~w_diff[DATA_W];
    assign w_q_final = r_neg_q ? -r_quot : r_quot;
    assign w_r_final = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_quot_nxt    = r_quot;
        w_rem_nxt     = r_rem;
        w_divisor_nxt = r_divisor;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_valid_nxt   = 1'b0;
        w_we_nxt      = 1'b0;
        w_waddr_nxt   = '0;
        w_wdata_nxt   = '0;
        w_stall       = 1'b0;

        if (bus.i_flush) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.i_valid && w_is_div) begin
                        w_stall = 1'b1;
                        if (bus.i_reg2 == '0) begin
                            // Divide by zero skips iteration; results are fixed, no sign fixup
                            w_quot_nxt  = '1;
                            w_rem_nxt   = bus.i_reg1;
                            w_neg_q_nxt = 1'b0;
                            w_neg_r_nxt = 1'b0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = StDone;
                        end else begin
                            w_quot_nxt    = w_abs1;
                            w_rem_nxt     = '0;
                            w_divisor_nxt = w_abs2;
                            w_neg_q_nxt   = w_sign1 ^ w_sign2;
                            w_neg_r_nxt   = w_sign1;
                            w_cnt_nxt     = CNT_W'(DATA_W);
                            w_state_nxt   = StBusy;
                        end
                    end else if (bus.i_valid) begin
                        w_valid_nxt = 1'b1;
                        w_we_nxt    = bus.i_we;
                        w_waddr_nxt = bus.i_waddr;
                        w_wdata_nxt = w_result;
                    end
                end
                StBusy: begin
                    w_stall    = 1'b1;
                    w_quot_nxt = {r_quot[DATA_W-2:0], w_fits};
                    w_rem_nxt  = w_fits ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = StDone;
                    end
                end
                StDone: begin
                    // The held divide is still on the inputs this cycle and is ignored
                    w_lo_nxt    = w_q_final;
                    w_hi_nxt    = w_r_final;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = StIdle;
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_quot    <= w_quot_nxt;
            r_rem     <= w_rem_nxt;
            r_divisor <= w_divisor_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_valid   <= w_valid_nxt;
            r_we      <= w_we_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wdata   <= w_wdata_nxt;
        end
    end

    // Stall is held low while reset is asserted even if a divide sits on the inputs
    assign bus.o_stall    = w_stall & rst_n;
    assign bus.o_we_id    = bus.i_we & bus.i_valid & ~bus.o_stall & (r_state == StIdle);
    assign bus.o_waddr_id = bus.i_waddr;
    assign bus.o_wdata_id = w_result;
    assign bus.o_valid    = r_valid;
    assign bus.o_we       = r_we;
    assign bus.o_waddr    = r_waddr;
    assign bus.o_wdata    = r_wdata;
    assign bus.o_hi       = r_hi;
    assign bus.o_lo       = r_lo;

endmodule

// File: tb/tb_ex_iter.sv
// Directed bench for ex_iter: the driver queues expected write-back results,
// a negedge monitor pops and compares them whenever valid_o is seen.
module tb_ex_iter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MFLO = 8'h12;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ex_iter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ex_iter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          chk_data;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid_o=1 wdata=%h required no output",
                         bus.o_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_we"}, DW'(bus.o_we), DW'(mon_e.we));
                if (mon_e.chk_data) begin
                    check({mon_e.name, "_waddr"}, DW'(bus.o_waddr), DW'(mon_e.waddr));
                    check({mon_e.name, "_wdata"}, bus.o_wdata, mon_e.wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.i_valid  = 1'b0;
        bus.i_aluop  = OP_NOP;
        bus.i_alusel = SEL_NOP;
        bus.i_reg1   = '0;
        bus.i_reg2   = '0;
        bus.i_waddr  = '0;
        bus.i_we     = 1'b0;
        bus.i_flush  = 1'b0;
    endtask

    task automatic set_in(input logic [7:0] op, input logic [2:0] sel, input logic [DW-1:0] r1,
                          input logic [DW-1:0] r2, input logic [AW-1:0] wa, input logic we);
        bus.i_valid  = 1'b1;
        bus.i_aluop  = op;
        bus.i_alusel = sel;
        bus.i_reg1   = r1;
        bus.i_reg2   = r2;
        bus.i_waddr  = wa;
        bus.i_we     = we;
        bus.i_flush  = 1'b0;
    endtask

    // Issue one single-cycle op; checks the ID forward now and queues the write-back
    task automatic alu(input string name, input logic [7:0] op, input logic [2:0] sel,
                       input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                       input logic [AW-1:0] wa, input logic we, input logic [DW-1:0] req);
        set_in(op, sel, r1, r2, wa, we);
        #1;
        check({name, "_fwd_data"}, bus.o_wdata_id, req);
        check({name, "_fwd_we"}, DW'(bus.o_we_id), DW'(we));
        exp_q.push_back('{we: we, waddr: wa, wdata: req, chk_data: 1'b1, name: name});
        tick();
    endtask

    // Hold a divide on the inputs while stalled, then check stall length and HI/LO
    task automatic divide(input string name, input logic [7:0] op, input logic [DW-1:0] r1,
                          input logic [DW-1:0] r2, input logic [DW-1:0] req_lo,
                          input logic [DW-1:0] req_hi, input int req_stall);
        int n;
        n = 0;
        set_in(op, SEL_NOP, r1, r2, 5'd9, 1'b1);
        @(negedge clk);
        while (bus.o_stall && n < 200) begin
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        check({name, "_stall_cycles"}, DW'(n), DW'(req_stall));
        check({name, "_done_fwd_we"}, DW'(bus.o_we_id), '0);
        tick();
        exp_q.push_back('{we: 1'b0, waddr: '0, wdata: '0, chk_data: 1'b0, name: name});
        idle_in();
        check({name, "_lo"}, bus.o_lo, req_lo);
        check({name, "_hi"}, bus.o_hi, req_hi);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required test completion");
        $fatal(1);
    end

    initial begin
        // Reset with a divide presented: nothing may stall or emit while reset is low
        set_in(OP_DIVU, SEL_NOP, 32'd100, 32'd7, 5'd1, 1'b1);
        #12;
        check("rst_valid", DW'(bus.o_valid), '0);
        check("rst_we", DW'(bus.o_we), '0);
        check("rst_waddr", DW'(bus.o_waddr), '0);
        check("rst_wdata", bus.o_wdata, '0);
        check("rst_hi", bus.o_hi, '0);
        check("rst_lo", bus.o_lo, '0);
        check("rst_stall", DW'(bus.o_stall), '0);
        idle_in();
        tick();
        rst_n = 1'b1;

        alu("or",       OP_OR,  SEL_LOGIC, 32'h0F0F0000, 32'h0000F0F0, 5'd3, 1'b1, 32'h0F0FF0F0);
        alu("sra",      OP_SRA, SEL_SHIFT, 32'd4, 32'h80000000, 5'd5, 1'b1, 32'hF8000000);
        alu("srl",      OP_SRL, SEL_SHIFT, 32'd4, 32'h80000000, 5'd6, 1'b1, 32'h08000000);
        alu("sll_wrap", OP_SLL, SEL_SHIFT, 32'h21, 32'h00000001, 5'd7, 1'b1, 32'h00000002);
        alu("and",      OP_AND, SEL_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd8, 1'b1, 32'h0F000F00);
        alu("xor",      OP_XOR, SEL_LOGIC, 32'hAAAA5555, 32'hFFFF0000, 5'd10, 1'b1, 32'h55555555);
        alu("nor",      OP_NOR, SEL_LOGIC, 32'h0F0F0F0F, 32'h00FF00FF, 5'd11, 1'b0, 32'hF000F000);
        alu("mismatch", OP_AND, SEL_SHIFT, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 1'b1, 32'h0);
        alu("nop",      OP_NOP, SEL_NOP,   32'h12345678, 32'h9ABCDEF0, 5'd13, 1'b1, 32'h0);
        idle_in();
        tick();

        divide("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        alu("mflo_14", OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd4, 1'b1, 32'd14);
        alu("mfhi_2",  OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd4, 1'b1, 32'd2);
        idle_in();

        divide("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        divide("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33);
        divide("div_5_0",  OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1);
        alu("mfhi_5", OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd2, 1'b1, 32'd5);
        idle_in();

        // Flush in the tenth busy cycle aborts the divide without touching HI/LO
        set_in(OP_DIVU, SEL_NOP, 32'd1000, 32'd3, 5'd9, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 10; k++) tick();
        check("flush_busy_stall", DW'(bus.o_stall), 32'd1);
        bus.i_flush = 1'b1;
        #1;
        check("flush_stall_drop", DW'(bus.o_stall), '0);
        tick();
        check("flush_bubble", DW'(bus.o_valid), '0);
        check("flush_hi", bus.o_hi, 32'd5);
        check("flush_lo", bus.o_lo, 32'hFFFFFFFF);
        alu("or_after_flush", OP_OR, SEL_LOGIC, 32'h00000F00, 32'h000000F0, 5'd14, 1'b1,
            32'h00000FF0);
        idle_in();
        tick();

        // Reset in the twentieth busy cycle clears outputs and HI/LO at once
        set_in(OP_DIVU, SEL_NOP, 32'd1000, 32'd3, 5'd9, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 20; k++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_stall", DW'(bus.o_stall), '0);
        check("midrst_valid", DW'(bus.o_valid), '0);
        check("midrst_wdata", bus.o_wdata, '0);
        check("midrst_hi", bus.o_hi, '0);
        check("midrst_lo", bus.o_lo, '0);
        idle_in();
        tick();
        tick();
        rst_n = 1'b1;
        divide("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        repeat (3) tick();
        check("queue_drained", DW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
